// File: rtl/pixel_frame_rx_if.sv
// Signal bundle between the pixel source / CNN core and the frame receiver.
// The master side drives pixels and classification results; the slave side is the receiver.
interface pixel_frame_rx_if #(
    parameter int GS_BITS  = 8,
    parameter int BCD_BITS = 4,
    parameter int IMG_DIM  = 30,
    parameter int CNT_BITS = 16
);
    localparam int POS_BITS = $clog2(IMG_DIM);

    logic [GS_BITS-1:0]  pixel_i;
    logic                pixel_i_valid;
    logic [GS_BITS-1:0]  pix_o;
    logic                pix_o_valid;
    logic [POS_BITS-1:0] pix_o_row;
    logic [POS_BITS-1:0] pix_o_col;
    logic                pix_o_sof;
    logic                pix_o_eof;
    logic                cls_done;
    logic [BCD_BITS-1:0] cls_digit;
    logic [BCD_BITS-1:0] digit_o;
    logic                digit_o_valid;
    logic                busy;
    logic                overrun;
    logic [CNT_BITS-1:0] frame_count;

    modport master (
        output pixel_i, pixel_i_valid, cls_done, cls_digit,
        input  pix_o, pix_o_valid, pix_o_row, pix_o_col, pix_o_sof, pix_o_eof,
        input  digit_o, digit_o_valid, busy, overrun, frame_count
    );

    modport slave (
        input  pixel_i, pixel_i_valid, cls_done, cls_digit,
        output pix_o, pix_o_valid, pix_o_row, pix_o_col, pix_o_sof, pix_o_eof,
        output digit_o, digit_o_valid, busy, overrun, frame_count
    );
endinterface

// File: rtl/pixel_frame_rx.sv
// Frame receiver: tags incoming pixels with row/col/sof/eof, then holds off new pixels
// until the CNN core reports a classification, which is forwarded as a one-cycle pulse.
module pixel_frame_rx #(
    parameter int GS_BITS  = 8,
    parameter int BCD_BITS = 4,
    parameter int IMG_DIM  = 30,
    parameter int CNT_BITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    pixel_frame_rx_if.slave  bus
);
    localparam int POS_BITS = $clog2(IMG_DIM);
    localparam logic [POS_BITS-1:0] LAST_POS = POS_BITS'(IMG_DIM - 1);

    typedef enum logic {RECV = 1'b0, WAIT = 1'b1} state_t;

    state_t              r_state, w_state_next;
    logic [POS_BITS-1:0] r_row, w_row_next;
    logic [POS_BITS-1:0] r_col, w_col_next;
    logic [GS_BITS-1:0]  r_pix, w_pix_next;
    logic                r_pix_valid, w_pix_valid_next;
    logic [POS_BITS-1:0] r_pix_row, w_pix_row_next;
    logic [POS_BITS-1:0] r_pix_col, w_pix_col_next;
    logic                r_sof, w_sof_next;
    logic                r_eof, w_eof_next;
    logic [BCD_BITS-1:0] r_digit, w_digit_next;
    logic                r_digit_valid, w_digit_valid_next;
    logic                r_overrun, w_overrun_next;
    logic [CNT_BITS-1:0] r_frame_count, w_frame_count_next;

    logic w_last_col;
    logic w_last_pix;

    assign w_last_col = (r_col == LAST_POS);
    assign w_last_pix = w_last_col && (r_row == LAST_POS);

    always_comb begin
        w_state_next       = r_state;
        w_row_next         = r_row;
        w_col_next         = r_col;
        w_pix_next         = r_pix;
        w_pix_valid_next   = 1'b0;
        w_pix_row_next     = r_pix_row;
        w_pix_col_next     = r_pix_col;
        w_sof_next         = r_sof;
        w_eof_next         = r_eof;
        w_digit_next       = r_digit;
        w_digit_valid_next = 1'b0;
        w_overrun_next     = r_overrun;
        w_frame_count_next = r_frame_count;

        case (r_state)
            RECV: begin
                // cls_done is deliberately ignored here: no frame is outstanding.
                if (bus.pixel_i_valid) begin
                    w_pix_next       = bus.pixel_i;
                    w_pix_valid_next = 1'b1;
                    w_pix_row_next   = r_row;
                    w_pix_col_next   = r_col;
                    w_sof_next       = (r_row == '0) && (r_col == '0);
                    w_eof_next       = w_last_pix;
                    if (w_last_pix) begin
                        w_row_next   = '0;
                        w_col_next   = '0;
                        w_state_next = WAIT;
                    end else if (w_last_col) begin
                        w_col_next = '0;
                        w_row_next = r_row + 1'b1;
                    end else begin
                        w_col_next = r_col + 1'b1;
                    end
                end
            end
            WAIT: begin
                // A pixel here is dropped even when cls_done arrives in the same cycle.
                if (bus.pixel_i_valid) begin
                    w_overrun_next = 1'b1;
                end
                if (bus.cls_done) begin
                    w_digit_next       = bus.cls_digit;
                    w_digit_valid_next = 1'b1;
                    w_frame_count_next = r_frame_count + 1'b1;
                    w_state_next       = RECV;
                end
            end
            default: w_state_next = RECV;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= RECV;
            r_row         <= '0;
            r_col         <= '0;
            r_pix         <= '0;
            r_pix_valid   <= 1'b0;
            r_pix_row     <= '0;
            r_pix_col     <= '0;
            r_sof         <= 1'b0;
            r_eof         <= 1'b0;
            r_digit       <= '0;
            r_digit_valid <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_row         <= w_row_next;
            r_col         <= w_col_next;
            r_pix         <= w_pix_next;
            r_pix_valid   <= w_pix_valid_next;
            r_pix_row     <= w_pix_row_next;
            r_pix_col     <= w_pix_col_next;
            r_sof         <= w_sof_next;
            r_eof         <= w_eof_next;
            r_digit       <= w_digit_next;
            r_digit_valid <= w_digit_valid_next;
            r_overrun     <= w_overrun_next;
            r_frame_count <= w_frame_count_next;
        end
    end

    assign bus.pix_o         = r_pix;
    assign bus.pix_o_valid   = r_pix_valid;
    assign bus.pix_o_row     = r_pix_row;
    assign bus.pix_o_col     = r_pix_col;
    assign bus.pix_o_sof     = r_sof;
    assign bus.pix_o_eof     = r_eof;
    assign bus.digit_o       = r_digit;
    assign bus.digit_o_valid = r_digit_valid;
    assign bus.busy          = (r_state == WAIT);
    assign bus.overrun       = r_overrun;
    assign bus.frame_count   = r_frame_count;
endmodule

// File: doc/pixel_frame_rx.md
Name: pixel_frame_rx

Overview:
- Receiving end of the pixel stream driven into the classifier: accepts the flat pixel_i/pixel_i_valid stream, one IMG_DIM x IMG_DIM image at a time.
- Tags each pixel with row/col and start-of-frame/end-of-frame markers for the CNN core.
- After the last pixel of an image it holds off until the core reports a classification, then presents that result as digit_o/digit_o_valid.
- Sits between the pixel source and the CNN core inside the top level.

Parameters:
GS_BITS, 8, grayscale pixel width
BCD_BITS, 4, classified digit width
IMG_DIM, 30, image side in pixels (frame = IMG_DIM*IMG_DIM pixels)
CNT_BITS, 16, width of frame_count
Derived localparam POS_BITS = $clog2(IMG_DIM) (5 at default)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous active-low reset (rst==0 at a rising edge resets)
pixel_i  in  GS_BITS  incoming pixel
pixel_i_valid  in  1  pixel_i valid this cycle; no back-pressure
pix_o  out  GS_BITS  registered pixel to CNN core
pix_o_valid  out  1  pix_o valid
pix_o_row  out  POS_BITS  row of pix_o, 0..IMG_DIM-1
pix_o_col  out  POS_BITS  column of pix_o, 0..IMG_DIM-1
pix_o_sof  out  1  pix_o is pixel (0,0)
pix_o_eof  out  1  pix_o is pixel (IMG_DIM-1,IMG_DIM-1)
cls_done  in  1  one-cycle pulse from core: classification complete
cls_digit  in  BCD_BITS  core result, valid with cls_done
digit_o  out  BCD_BITS  classified digit
digit_o_valid  out  1  one-cycle pulse, digit_o valid
busy  out  1  1 while waiting for classification
overrun  out  1  sticky: pixel arrived while busy
frame_count  out  CNT_BITS  number of completed classifications

Behaviour:
- Reset (rst==0 at clk edge): state=RECV, row=col=0. All outputs 0: pix_o, pix_o_valid, pix_o_row, pix_o_col, pix_o_sof, pix_o_eof, digit_o, digit_o_valid, busy, overrun, frame_count. Reset mid-frame or mid-wait discards the partial frame; the next pixel after reset is (0,0).
- States: RECV (accepting pixels), WAIT (frame complete, awaiting cls_done).
- RECV, pixel_i_valid=1: next cycle pix_o=pixel_i, pix_o_valid=1, row/col = current counters, sof=(row==0 && col==0), eof=(row==IMG_DIM-1 && col==IMG_DIM-1). Latency 1 cycle.
- Counter advance: col++. At col==IMG_DIM-1, col wraps to 0 and row++. At eof, row and col wrap to 0 and state goes to WAIT.
- RECV, pixel_i_valid=0: pix_o_valid=0; pix_o, row, col and flags hold their last values. Gaps between pixels are legal.
- busy: registered, equals (state==WAIT). Rises in the same cycle pix_o_eof is presented.
- WAIT, pixel_i_valid=1: pixel dropped, no pix_o_valid, counters unchanged, overrun<=1. overrun clears only on reset.
- WAIT, cls_done=1: next cycle digit_o=cls_digit and digit_o_valid=1 for exactly one cycle; frame_count++ (wraps mod 2^CNT_BITS); state goes to RECV; busy goes to 0. digit_o holds its value until the next result.
- Same cycle cls_done and pixel_i_valid in WAIT: the pixel counts as overrun and is dropped; cls_done is processed normally. The first accepted pixel of the next frame is the one arriving in the cycle after.
- RECV, cls_done=1: ignored; no digit_o_valid, no count change.
- cls_digit > 9: passed through unchanged; no checking is done here.

Test Plan:
- Reset hold: rst=0 for 2 cycles with pixel_i_valid=1 -> all outputs 0, no pix_o_valid.
- Single frame: 900 contiguous pixels, value = index mod 256 -> 900 pix_o_valid pulses with 1-cycle latency. Pixel 31 appears as row=1, col=1, value 0x1F. sof only on first, eof only on 900th. busy=1 from the eof cycle. Then cls_done with cls_digit=7 -> digit_o=7, digit_o_valid for 1 cycle, frame_count=1, busy=0.
- Gapped input: valid toggles 1,0,1,0 across a frame -> still exactly 900 outputs, correct row/col, eof on the last pixel.
- Overrun: 5 pixels sent during WAIT -> none output, overrun=1 and stays 1 through the next frame. The next frame after cls_done starts at (0,0).
- Collision: cls_done and pixel_i_valid in the same WAIT cycle -> that pixel dropped, overrun=1, digit_o_valid next cycle; the following pixel is output with sof=1.
- Reset mid-frame after 450 pixels, then a full 900-pixel frame -> first output pixel is (0,0) with sof=1, eof on the 900th, frame_count=0 until cls_done.
